temporizador_mag: RTL
=====================

TEMPORIZADOR_MAG -- requirements
Module: temporizador_mag

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 clearn  in  1  active-low synchronous clear, the same signal as the control logic's clearn.
REQ-005 digit_valid  in  1  one-cycle strobe: new keypad digit present on digit_in.
REQ-006 digit_in  in  4  BCD keypad digit; values 10-15 are invalid.
REQ-007 mag_on  in  1  magnetron latch output Q; high enables counting.
REQ-008 tick_1hz  in  1  one-cycle pulse once per second.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  out  4 each  registered BCD time remaining, MM:SS.
REQ-010 timer_done  out  1  registered level, consumed by the magnetron control logic to force R=1.

Function
REQ-011 The FSM SHALL have states IDLE (time 0000, not running), SET (time nonzero, not running), RUN and DONE.
REQ-012 Priority per edge SHALL be: clearn, then digit entry, then tick decrement.
REQ-013 clearn low SHALL force all digits to 0, timer_done to 0 and state to IDLE, in any state including RUN.
REQ-014 Digit entry SHALL be accepted only when digit_valid=1, digit_in<=9, mag_on=0 and clearn=1.
REQ-015 An accepted digit SHALL shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in. The old min_tens is discarded.
REQ-016 After an accepted digit, the state SHALL be SET if the resulting time is nonzero, else IDLE.
REQ-017 An accepted digit in DONE SHALL also clear timer_done on the same edge.
REQ-018 An invalid digit, or any digit_valid while mag_on=1, SHALL be ignored with no state change.
REQ-019 In SET, mag_on=1 SHALL move the state to RUN on the next edge.
REQ-020 In IDLE, mag_on=1 SHALL set timer_done=1 and state DONE on the next edge, so a zero time never runs.
REQ-021 In RUN, tick_1hz=1 with mag_on=1 SHALL decrement the time by one second on that edge.
REQ-022 Decrement SHALL use BCD borrow, with no binary-coded values ever appearing on the outputs:
- sec_ones wraps 0->9 and borrows from sec_tens;
- sec_tens wraps 0->5 and borrows from min_ones;
- min_ones wraps 0->9 and borrows from min_tens.
REQ-023 Entered seconds above 59 (for example 0:99) SHALL count down linearly (99, 98, ...) with no normalisation.
REQ-024 A decrement that produces 0000 SHALL assert timer_done=1 and enter DONE on the same edge.
REQ-025 In RUN, mag_on=0 (stop pressed or door opened) SHALL move the state to SET with digits held. Ticks SHALL be ignored while mag_on=0.
REQ-026 In DONE, timer_done SHALL stay 1 and the digits SHALL stay 0000 until clearn or an accepted digit.
REQ-027 Latency SHALL be:
- tick to updated digits: 1 clock;
- final tick to timer_done: 1 clock.

Reset
REQ-028 resetn low SHALL asynchronously force all digits to 0, timer_done to 0 and state to IDLE.
REQ-029 Reset release SHALL take effect on the first clk edge with resetn high; no input is sampled before that edge.
REQ-030 Reset asserted mid-RUN SHALL abandon the count with no timer_done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding plus these constants: BCD_MAX=9, SEC_TENS_WRAP=5 and DIGIT_W=4.
REQ-032 One sub-module, bcd_digit_dec, SHALL implement one BCD digit with load, decrement, a parameterised wrap value, borrow-in and borrow-out. It SHALL be instantiated four times.
REQ-033 The FSM and the entry shift SHALL reside in temporizador_mag; estimated size is 150-250 lines in total.

Verification
REQ-034 Entry and run: digits 1,3,0 entered with mag_on=0 -> outputs 01:30, state SET. Then mag_on=1 and 90 ticks -> 01:29 after the first tick, 00:59 after 31 ticks, and 00:00 with timer_done=1 one clock after tick 90.
REQ-035 Borrow chain: 10:00 loaded, one tick -> 09:59. Entry 0:99, one tick -> 00:98.
REQ-036 Pause: at 00:45 drop mag_on and apply 3 ticks -> digits hold 00:45, state SET. Raise mag_on and apply 1 tick -> 00:44.
REQ-037 Priorities: clearn=0 on the same edge as a tick in RUN -> 00:00, timer_done=0, IDLE. digit_valid while mag_on=1 -> ignored. digit_in=12 -> ignored.
REQ-038 Edge cases: mag_on=1 in IDLE -> timer_done=1 next edge. A digit entered in DONE -> timer_done=0, shifted value shown. resetn pulsed mid-RUN -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/temporizador_mag_pkg.sv
// Shared state encoding and BCD constants for the microwave countdown timer.
package temporizador_mag_pkg;

  localparam int DIGIT_W       = 4;
  localparam int BCD_MAX       = 9;
  localparam int SEC_TENS_WRAP = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/temporizador_mag_bcd_digit_dec.sv
// One BCD countdown digit: synchronous clear, parallel load, and decrement
// with a configurable wrap value and a ripple borrow chain.
module bcd_digit_dec
  import temporizador_mag_pkg::*;
#(
  parameter int WRAP = BCD_MAX
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  // Borrow ripples through every digit that currently reads zero.
  assign borrow_out = borrow_in && (q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec && borrow_in) begin
      if (q == '0) q <= DIGIT_W'(WRAP);
      else         q <= q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/temporizador_mag.sv
// Keypad-loaded MM:SS countdown timer that signals the magnetron control
// logic when the programmed cook time has elapsed.
//
// state | meaning
// IDLE  | time is 00:00, not running
// SET   | time nonzero, waiting for mag_on
// RUN   | counting down on tick_1hz while mag_on
// DONE  | time expired, timer_done held until clear or new digit
module temporizador_mag
  import temporizador_mag_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               clearn,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               mag_on,
  input  logic               tick_1hz,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               timer_done
);

  state_t     state;
  logic       clr;
  logic       accept;
  logic       dec;
  logic       shift_nonzero;
  logic       at_one;
  logic       time_zero;
  logic [3:0] borrow;

  assign clr    = !clearn;
  assign accept = clearn && digit_valid && !mag_on && (digit_in <= DIGIT_W'(BCD_MAX));
  assign dec    = clearn && !accept && (state == RUN) && mag_on && tick_1hz;

  assign shift_nonzero = |{min_ones, sec_tens, sec_ones, digit_in};
  // 00:01 is the only value whose decrement lands on 00:00.
  assign at_one    = ({min_tens, min_ones, sec_tens} == '0) && (sec_ones == DIGIT_W'(1));
  assign time_zero = borrow[3];

  bcd_digit_dec #(.WRAP(BCD_MAX)) u_sec_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .load       (accept),
    .load_val   (digit_in),
    .dec        (dec),
    .borrow_in  (1'b1),
    .q          (sec_ones),
    .borrow_out (borrow[0])
  );

  bcd_digit_dec #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .load       (accept),
    .load_val   (sec_ones),
    .dec        (dec),
    .borrow_in  (borrow[0]),
    .q          (sec_tens),
    .borrow_out (borrow[1])
  );

  bcd_digit_dec #(.WRAP(BCD_MAX)) u_min_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .load       (accept),
    .load_val   (sec_tens),
    .dec        (dec),
    .borrow_in  (borrow[1]),
    .q          (min_ones),
    .borrow_out (borrow[2])
  );

  bcd_digit_dec #(.WRAP(BCD_MAX)) u_min_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .load       (accept),
    .load_val   (min_ones),
    .dec        (dec),
    .borrow_in  (borrow[2]),
    .q          (min_tens),
    .borrow_out (borrow[3])
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      timer_done <= 1'b0;
    end else if (!clearn) begin
      state      <= IDLE;
      timer_done <= 1'b0;
    end else if (accept) begin
      state      <= shift_nonzero ? SET : IDLE;
      timer_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mag_on) begin
            state      <= DONE;
            timer_done <= 1'b1;
          end
        end
        SET: begin
          // A zero time must never be allowed to run.
          if (mag_on) begin
            if (time_zero) begin
              state      <= DONE;
              timer_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!mag_on) begin
            state <= SET;
          end else if (tick_1hz && at_one) begin
            state      <= DONE;
            timer_done <= 1'b1;
          end
        end
        DONE: begin
          timer_done <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          timer_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
